// File: rtl/burst_returner.sv
// burst_returner: in-order completion buffer between burst_handler and the front end.
// Optional macro BURST_RETURNER_WRITE_ACK_EN: store and return write completions.
module burst_returner #(
   parameter int unsigned DEPTH        = 8,
   parameter int unsigned AFULL_THRESH = 6,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned INDEX_WIDTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     returner_valid,
   input  logic                     returner_type,
   input  logic [DATA_WIDTH-1:0]    returner_data,
   input  logic [INDEX_WIDTH-1:0]   returner_index,
   output logic                     ret_valid,
   input  logic                     ret_ready,
   output logic                     ret_type,
   output logic [DATA_WIDTH-1:0]    ret_data,
   output logic [INDEX_WIDTH-1:0]   ret_index,
   output logic                     free_valid,
   output logic [INDEX_WIDTH-1:0]   free_index,
   output logic                     almost_full,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_param_check
      $error("burst_returner: illegal DEPTH/AFULL_THRESH");
   end

   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic                   mem_type  [DEPTH];
   logic [INDEX_WIDTH-1:0] mem_index [DEPTH];
   logic [DATA_WIDTH-1:0]  mem_data  [DEPTH];

   logic                   storable;
   logic [DATA_WIDTH-1:0]  store_data;
   logic                   full;
   logic                   pop;
   logic                   push;
   logic                   drop;

`ifdef BURST_RETURNER_WRITE_ACK_EN
   always_comb begin
      storable   = returner_valid;
      store_data = returner_type ? '0 : returner_data;
   end
`else
   always_comb begin
      storable   = returner_valid && !returner_type;
      store_data = returner_data;
   end
`endif

   // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
   always_comb begin
      full      = (count == CW'(DEPTH));
      ret_valid = (count != '0);
      pop       = ret_valid && ret_ready;
      push      = storable && (!full || pop);
      drop      = storable && full && !pop;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_type[wr_ptr]  <= returner_type;
         mem_index[wr_ptr] <= returner_index;
         mem_data[wr_ptr]  <= store_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         free_valid <= 1'b0;
         free_index <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (drop) overflow <= 1'b1;
         free_valid <= pop && !mem_type[rd_ptr];
         free_index <= (pop && !mem_type[rd_ptr]) ? mem_index[rd_ptr] : '0;
      end
   end

   // Head fields are gated by ret_valid so an empty FIFO presents all zeros.
   always_comb begin
      ret_type  = 1'b0;
      ret_data  = '0;
      ret_index = '0;
      if (ret_valid) begin
         ret_type  = mem_type[rd_ptr];
         ret_data  = mem_data[rd_ptr];
         ret_index = mem_index[rd_ptr];
      end
   end

   always_comb almost_full = (count >= CW'(AFULL_THRESH));

endmodule

// File: tb/tb_burst_returner.sv
// Scoreboard bench for burst_returner: expected completions queued, checked at each negedge.
module tb_burst_returner;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned AF    = 6;

   typedef struct packed {
      logic        typ;
      logic [3:0]  idx;
      logic [31:0] data;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rv = 1'b0, rt = 1'b0, ready = 1'b0;
   logic [31:0] rd = '0;
   logic [3:0]  ri = '0;
   logic        ret_valid, ret_type, free_valid, almost_full, overflow;
   logic [31:0] ret_data;
   logic [3:0]  ret_index, free_index;
   logic [3:0]  count;

   int   errors = 0;
   int   checks = 0;
   bit   mon_en = 1'b0;
   ent_t sb[$];
   bit   m_ovf = 1'b0;
   bit   exp_free_pend = 1'b0;
   logic [3:0] exp_free_idx = '0;

   burst_returner #(.DEPTH(DEPTH), .AFULL_THRESH(AF), .DATA_WIDTH(32), .INDEX_WIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .returner_valid(rv), .returner_type(rt), .returner_data(rd), .returner_index(ri),
      .ret_valid(ret_valid), .ret_ready(ready), .ret_type(ret_type), .ret_data(ret_data),
      .ret_index(ret_index), .free_valid(free_valid), .free_index(free_index),
      .almost_full(almost_full), .overflow(overflow), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         bit   pop_m;
         bit   storable;
         ent_t e;
         if (exp_free_pend) begin
            chk("free_valid", free_valid, 1);
            chk("free_index", free_index, exp_free_idx);
         end else begin
            chk("free_idle", free_valid, 0);
         end
         chk("count", count, sb.size());
         chk("ret_valid", ret_valid, sb.size() != 0);
         chk("almost_full", almost_full, sb.size() >= AF);
         chk("overflow", overflow, m_ovf);
         if (sb.size() != 0) begin
            chk("head_type", ret_type, sb[0].typ);
            chk("head_index", ret_index, sb[0].idx);
            chk("head_data", ret_data, sb[0].data);
         end else begin
            chk("empty_zero", {ret_type, ret_index, ret_data}, 0);
         end
         pop_m         = (sb.size() != 0) && ready;
         exp_free_pend = pop_m && !sb[0].typ;
         exp_free_idx  = pop_m ? sb[0].idx : 4'h0;
         if (pop_m) void'(sb.pop_front());
`ifdef BURST_RETURNER_WRITE_ACK_EN
         storable = rv;
`else
         storable = rv && !rt;
`endif
         if (storable) begin
            e.typ  = rt;
            e.idx  = ri;
            e.data = rt ? 32'h0 : rd;
            if (sb.size() < DEPTH) sb.push_back(e);
            else m_ovf = 1'b1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic t, input logic [3:0] idx,
                        input logic [31:0] d, input logic r);
      rv = v; rt = t; ri = idx; rd = d; ready = r;
      step();
   endtask

   task automatic drain();
      int n = 0;
      rv = 1'b0; ready = 1'b1;
      while (count != 0 && n < 40) begin
         step();
         n++;
      end
      chk("drain_empty", count, 0);
      ready = 1'b0;
      step();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ret"}, {ret_valid, ret_type, ret_data, ret_index}, 0);
      chk({tag, "_free"}, {free_valid, free_index}, 0);
      chk({tag, "_flags"}, {almost_full, overflow}, 0);
      chk({tag, "_count"}, count, 0);
   endtask

   // Reset lands between edges; outputs must clear without waiting for a clock.
   task automatic async_reset(input string tag);
      rv = 1'b0; ready = 1'b0;
      #2 rst = 1'b1;
      #1 check_zero(tag);
      sb.delete();
      m_ovf = 1'b0;
      exp_free_pend = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: timeout reached, expected finish");
      $fatal(1);
   end

   initial begin
      int pushes;
      int cyc;
      #2 check_zero("reset");
      @(posedge clk);
      #1 rst = 1'b0;
      mon_en = 1'b1;
      step();

      // 1: single read
      drive(1, 0, 4'd3, 32'hA5, 1);
      chk("t1_valid", ret_valid, 1);
      chk("t1_index", ret_index, 3);
      chk("t1_data", ret_data, 32'hA5);
      drive(0, 0, 0, 0, 1);
      chk("t1_free_valid", free_valid, 1);
      chk("t1_free_index", free_index, 3);
      chk("t1_count", count, 0);
      drive(0, 0, 0, 0, 0);
      chk("t1_free_pulse_end", free_valid, 0);

      // 2: fill past full with no ready
      for (int i = 0; i < 9; i++) begin
         drive(1, 0, 4'(i), 32'h100 + 32'(i), 0);
         if (i == 4) chk("t2_af_below", almost_full, 0);
         if (i == 5) chk("t2_af_at6", almost_full, 1);
      end
      chk("t2_overflow", overflow, 1);
      chk("t2_count", count, 8);
      drain();
      async_reset("t2_rst");

      // 3: full with simultaneous push and pop
      for (int i = 0; i < 8; i++) drive(1, 0, 4'(i), 32'h200 + 32'(i), 0);
      drive(1, 0, 4'd9, 32'h209, 1);
      chk("t3_count", count, 8);
      chk("t3_no_ovf", overflow, 0);
      drain();

      // 4: write completion
      drive(1, 1, 4'd2, 32'hDEAD, 0);
`ifdef BURST_RETURNER_WRITE_ACK_EN
      chk("t4_count", count, 1);
      chk("t4_type", ret_type, 1);
      chk("t4_data", ret_data, 0);
      chk("t4_index", ret_index, 2);
      drive(0, 0, 0, 0, 1);
      chk("t4_no_free", free_valid, 0);
      drive(0, 0, 0, 0, 0);
`else
      for (int i = 0; i < 3; i++) begin
         chk("t4_count", count, 0);
         chk("t4_valid", ret_valid, 0);
         drive(0, 0, 0, 0, 0);
      end
`endif

      // 5: interleaved traffic across pointer wrap
      pushes = 0;
      cyc = 0;
      while (pushes < 20 && cyc < 200) begin
         logic p;
         p = ($urandom_range(0, 1) == 1) && (sb.size() < DEPTH - 1);
         drive(p, 0, 4'(pushes), $urandom, logic'($urandom_range(0, 1)));
         if (p) pushes++;
         cyc++;
      end
      chk("t5_pushes", 32'(pushes), 20);
      drain();

      // 6: reset mid-operation
      for (int i = 0; i < 9; i++) drive(1, 0, 4'(i + 4), 32'h300 + 32'(i), 0);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1);
      ready = 1'b0;
      chk("t6_held", count, 5);
      chk("t6_ovf", overflow, 1);
      async_reset("t6_rst");
      drive(1, 0, 4'd1, 32'h11, 0);
      chk("t6_first", ret_index, 1);
      chk("t6_first_data", ret_data, 32'h11);
      drain();

      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
